block_xfer_ctrl: RTL
====================

# block_xfer_ctrl

Parametrised block-transfer controller between primary memory and the secondary (disk) memory. It is the successor to the fixed single-word store/load controller. It moves a run-time-selected number of consecutive words in either direction, pipelined at one word per clock, and holds the control unit with `busy` until the block is complete. It sits between the CPU's unit-control STD/LDD requests and the two synchronous RAMs.

## Interface
Parameters:
- `DATA_W`, 16, word width of both memories
- `P_ADDR_W`, 16, primary memory address width
- `S_ADDR_W`, 15, secondary memory address width
- `LEN_W`, 8, width of the block-length input (max block `2^LEN_W-1` words)

Ports:
- `clk` in 1: single system clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `start` in 1: request a transfer; sampled only in IDLE
- `dir` in 1: 0 = store (primary→secondary), 1 = load (secondary→primary)
- `len` in LEN_W: number of words to move
- `p_base` in P_ADDR_W: first primary address
- `s_base` in S_ADDR_W: first secondary address
- `p_q` in DATA_W: primary RAM read data, 1-cycle latency
- `s_q` in DATA_W: secondary RAM read data, 1-cycle latency
- `p_addr` out P_ADDR_W: primary RAM address
- `p_data` out DATA_W: primary RAM write data
- `p_we` out 1: primary write enable
- `s_addr` out S_ADDR_W: secondary RAM address
- `s_data` out DATA_W: secondary RAM write data
- `s_we` out 1: secondary write enable
- `busy` out 1: transfer in progress; control unit waits while high
- `done` out 1: one-cycle completion pulse

## Operation
- Reset: all outputs 0, state IDLE, and all internal counters and latched bases 0.
- States: IDLE, RUN, FLUSH, DONE.
- **IDLE:** on `start`=1, latch `dir`, `len`, `p_base`, and `s_base`; clear `rd_idx` and `wr_idx`.
  - If latched `len`≠0, go to RUN.
  - If `len`=0, go directly to DONE, with no reads and no writes.
- **RUN:**
  - The source address is `src_base + rd_idx`, and `rd_idx` increments each cycle.
  - From the second RUN cycle on, the destination write is active: address `dst_base + wr_idx`, data = source `*_q`, WE=1, and `wr_idx` increments.
  - When `rd_idx` = `len-1` is issued, go to FLUSH.
- **FLUSH:** perform the final write (`wr_idx` = `len-1`), then go to DONE.
- **DONE:** `done`=1 for one cycle, then IDLE unconditionally.
- Direction mapping:
  - `dir`=0: source is primary and destination is secondary; `p_we` is held 0.
  - `dir`=1: source is secondary and destination is primary; `s_we` is held 0.
- The non-active memory's address is held at its latched base.
- Address arithmetic wraps modulo 2^P_ADDR_W and 2^S_ADDR_W independently.
- Write data is a combinational pass-through of the source `*_q`. Every other output is driven from registers.
- `start` in RUN, FLUSH, or DONE is ignored, and is not queued.
- Changes to `len`, bases, or `dir` after the start cycle have no effect.
- Assertion of `rst` mid-transfer aborts immediately: WE drops, `busy` and `done` clear, and no further writes occur.

## Timing
- With `start` sampled at edge E0:
  - `busy` is high from E0 for `len+1` cycles (RUN × `len`, FLUSH × 1).
  - `done` is high in the following cycle.
- Write k (k = 0..`len-1`) occurs in the cycle after read k was issued.
- Total cycles from `start` to `done` pulse: `len+2`.
- Back-to-back: the earliest next accepted `start` is the cycle after `done`.
- `len`=0: `busy` never rises; `done` pulses one cycle after E0.
- Throughput: one word per cycle in steady state.

## Configuration
- `XFER_CHECKSUM_EN` defined: adds output `checksum` [DATA_W-1:0].
  - Cleared on accepted `start`.
  - Accumulates (modulo 2^DATA_W) every written word.
  - Holds its final value from the `done` cycle until the next accepted `start`.
  - Reset value is 0.
- `XFER_CHECKSUM_EN` undefined: port and accumulator are absent. All other behaviour is identical.

## Test plan
- **Store, `len`=4:** `dir`=0, `p_base`=0x0010, `s_base`=0x0100, primary[0x10..0x13] = 1, 2, 3, 4 -> secondary[0x100..0x103] = 1, 2, 3, 4; `busy` high 5 cycles; `done` pulse at cycle 6; `p_we` never 1.
- **Load with wrap:** `dir`=1, `s_base`=0x7FFE, `len`=3 -> reads 0x7FFE, 0x7FFF, 0x0000; writes land at the three consecutive primary addresses.
- **Zero length and ignored start:**
  - `len`=0 -> no WE pulse; `done` one cycle after `start`; `busy` stays 0.
  - `start` re-pulsed mid-transfer -> ignored; exactly one `done`.
- **Reset mid-transfer:** `len`=8, `rst` asserted after 3 writes -> WE, `busy`, and `done` go 0 asynchronously; only 3 destination words are modified; the next `start` works normally.
- **Checksum (`XFER_CHECKSUM_EN`):** words 0xFFFF, 0x0002 -> `checksum`=0x0001 at `done`; held until the next `start`.

Source files
------------

// File: rtl/block_xfer_ctrl.sv
// block_xfer_ctrl: pipelined block copy between primary and secondary RAM.
// Moves len consecutive words (one per clock) in the direction given by dir.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start, dir, len   transfer request, direction (1 = load), word count
//   p_base, s_base    first primary / secondary address of the block
//   p_q, s_q          RAM read data (1-cycle latency)
//   p_addr/p_data/p_we  primary RAM port
//   s_addr/s_data/s_we  secondary RAM port
//   busy, done        transfer in progress, one-cycle completion pulse
//   checksum          (only with XFER_CHECKSUM_EN) sum of written words
//
// Optional feature macro: XFER_CHECKSUM_EN.

module block_xfer_ctrl #(
   parameter int DATA_W   = 16,
   parameter int P_ADDR_W = 16,
   parameter int S_ADDR_W = 15,
   parameter int LEN_W    = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                dir,
   input  logic [LEN_W-1:0]    len,
   input  logic [P_ADDR_W-1:0] p_base,
   input  logic [S_ADDR_W-1:0] s_base,
   input  logic [DATA_W-1:0]   p_q,
   input  logic [DATA_W-1:0]   s_q,
   output logic [P_ADDR_W-1:0] p_addr,
   output logic [DATA_W-1:0]   p_data,
   output logic                p_we,
   output logic [S_ADDR_W-1:0] s_addr,
   output logic [DATA_W-1:0]   s_data,
   output logic                s_we,
`ifdef XFER_CHECKSUM_EN
   output logic [DATA_W-1:0]   checksum,
`endif
   output logic                busy,
   output logic                done
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // ------------------------------------------------------------
   // State and latched request
   // ------------------------------------------------------------
   logic [1:0]          r_state;
   logic                r_dir;
   logic [LEN_W-1:0]    r_len;
   logic [P_ADDR_W-1:0] r_p_base;
   logic [S_ADDR_W-1:0] r_s_base;
   logic [LEN_W-1:0]    r_rd_idx;
   logic [LEN_W-1:0]    r_wr_idx;

   // Registered outputs
   logic [P_ADDR_W-1:0] r_p_addr;
   logic [S_ADDR_W-1:0] r_s_addr;
   logic                r_p_we;
   logic                r_s_we;
   logic                r_busy;
   logic                r_done;

   // Next-state values
   logic [1:0]          w_state_nx;
   logic [LEN_W-1:0]    w_rd_idx_nx;
   logic [LEN_W-1:0]    w_wr_idx_nx;
   logic [P_ADDR_W-1:0] w_p_addr_nx;
   logic [S_ADDR_W-1:0] w_s_addr_nx;
   logic                w_p_we_nx;
   logic                w_s_we_nx;
   logic                w_busy_nx;
   logic                w_done_nx;

   logic                w_accept;
   logic                w_wr_act;
   logic                w_rd_last;
   logic [LEN_W-1:0]    w_rd_inc;
   logic [LEN_W-1:0]    w_wr_next;

   // ------------------------------------------------------------
   // Address helpers: offsets wrap modulo the address width
   // ------------------------------------------------------------
   function automatic logic [P_ADDR_W-1:0] f_p_off(
      input logic [P_ADDR_W-1:0] b,
      input logic [LEN_W-1:0]    i
   );
      return b + P_ADDR_W'(i);
   endfunction

   function automatic logic [S_ADDR_W-1:0] f_s_off(
      input logic [S_ADDR_W-1:0] b,
      input logic [LEN_W-1:0]    i
   );
      return b + S_ADDR_W'(i);
   endfunction

   assign w_accept  = (r_state == ST_IDLE) && start;
   assign w_wr_act  = r_p_we | r_s_we;
   assign w_rd_last = (r_rd_idx == (r_len - LEN_W'(1)));
   assign w_rd_inc  = r_rd_idx + LEN_W'(1);

   // The first write of a block uses index 0; later ones step by one.
   assign w_wr_next = w_wr_act ? (r_wr_idx + LEN_W'(1)) : '0;

   // ------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------
   always_comb begin
      w_state_nx  = r_state;
      w_rd_idx_nx = r_rd_idx;
      w_wr_idx_nx = r_wr_idx;
      w_p_addr_nx = r_p_addr;
      w_s_addr_nx = r_s_addr;
      w_p_we_nx   = 1'b0;
      w_s_we_nx   = 1'b0;
      w_busy_nx   = r_busy;
      w_done_nx   = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_rd_idx_nx = '0;
               w_wr_idx_nx = '0;
               // Source issues read 0 at its base; the other side
               // parks at its base until the first write.
               w_p_addr_nx = p_base;
               w_s_addr_nx = s_base;
               if (len != '0) begin
                  w_state_nx = ST_RUN;
                  w_busy_nx  = 1'b1;
               end else begin
                  w_state_nx = ST_DONE;
                  w_done_nx  = 1'b1;
               end
            end
         end

         ST_RUN: begin
            // The read issued now returns next cycle and is written then.
            w_wr_idx_nx = w_wr_next;
            if (r_dir) begin
               w_p_we_nx   = 1'b1;
               w_p_addr_nx = f_p_off(r_p_base, w_wr_next);
               if (!w_rd_last) begin
                  w_s_addr_nx = f_s_off(r_s_base, w_rd_inc);
               end
            end else begin
               w_s_we_nx   = 1'b1;
               w_s_addr_nx = f_s_off(r_s_base, w_wr_next);
               if (!w_rd_last) begin
                  w_p_addr_nx = f_p_off(r_p_base, w_rd_inc);
               end
            end
            if (w_rd_last) begin
               w_state_nx = ST_FLUSH;
            end else begin
               w_rd_idx_nx = w_rd_inc;
            end
         end

         ST_FLUSH: begin
            // Last write is on the bus this cycle.
            w_state_nx = ST_DONE;
            w_busy_nx  = 1'b0;
            w_done_nx  = 1'b1;
         end

         ST_DONE: begin
            w_state_nx = ST_IDLE;
         end

         default: begin
            w_state_nx = ST_IDLE;
            w_busy_nx  = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_dir    <= 1'b0;
         r_len    <= '0;
         r_p_base <= '0;
         r_s_base <= '0;
         r_rd_idx <= '0;
         r_wr_idx <= '0;
         r_p_addr <= '0;
         r_s_addr <= '0;
         r_p_we   <= 1'b0;
         r_s_we   <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_rd_idx <= w_rd_idx_nx;
         r_wr_idx <= w_wr_idx_nx;
         r_p_addr <= w_p_addr_nx;
         r_s_addr <= w_s_addr_nx;
         r_p_we   <= w_p_we_nx;
         r_s_we   <= w_s_we_nx;
         r_busy   <= w_busy_nx;
         r_done   <= w_done_nx;
         if (w_accept) begin
            r_dir    <= dir;
            r_len    <= len;
            r_p_base <= p_base;
            r_s_base <= s_base;
         end
      end
   end

   // ------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------
   assign p_addr = r_p_addr;
   assign s_addr = r_s_addr;
   assign p_we   = r_p_we;
   assign s_we   = r_s_we;
   assign busy   = r_busy;
   assign done   = r_done;

   // Write data passes straight from the opposite RAM's read port.
   assign p_data = s_q;
   assign s_data = p_q;

`ifdef XFER_CHECKSUM_EN
   logic [DATA_W-1:0] r_cs;
   logic [DATA_W-1:0] w_wdata;

   assign w_wdata = r_dir ? s_q : p_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cs <= '0;
      end else if (w_accept) begin
         r_cs <= '0;
      end else if (w_wr_act) begin
         r_cs <= r_cs + w_wdata;
      end
   end

   assign checksum = r_cs;
`endif

endmodule
